// File: rtl/c_readout_if.sv
// c_readout_if: groups the CFU command/response handshake, the C buffer read port and
// the write-side stall input of the C buffer read engine.
//   slave  modport: the read engine (c_readout)
//   master modport: the CPU / C buffer side that drives commands and read data
interface c_readout_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LANES  = 4
);
    localparam int unsigned DATA_W = 32 * LANES;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        funct;
    logic [31:0]       input0;
    logic [31:0]       input1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              c_rd_en;
    logic [ADDR_W-1:0] c_rd_addr;
    logic [DATA_W-1:0] c_rd_data;
    logic              c_wr_en;
    logic              busy;

    modport slave (
        input  cmd_valid, funct, input0, input1, rsp_ready, c_rd_data, c_wr_en,
        output cmd_ready, rsp_valid, rsp_data, c_rd_en, c_rd_addr, busy
    );

    modport master (
        output cmd_valid, funct, input0, input1, rsp_ready, c_rd_data, c_wr_en,
        input  cmd_ready, rsp_valid, rsp_data, c_rd_en, c_rd_addr, busy
    );
endinterface

// File: rtl/c_readout.sv
// c_readout: read-side engine for the C (result) buffer.
// Accepts CFU commands (1 = clear pointer, 3 = seek-read, 4 = next-read, others = no-op),
// reads one C buffer word, selects a 32-bit lane and returns it as the CFU response.
// Ports:
//   clk     clock
//   rst_n   synchronous active-low reset
//   bus_io  c_readout_if.slave: command/response handshake, C buffer read port, write stall
module c_readout #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LANES  = 4
) (
    input logic       clk,
    input logic       rst_n,
    c_readout_if.slave bus_io
);
    localparam int unsigned LaneW = $clog2(LANES);

    localparam logic [2:0] FunctClear = 3'd1;
    localparam logic [2:0] FunctSeek  = 3'd3;
    localparam logic [2:0] FunctNext  = 3'd4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_addr_q, ptr_addr_d;
    logic [LaneW-1:0]  ptr_lane_q, ptr_lane_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LaneW-1:0]  cur_lane_q, cur_lane_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    logic accept;
    logic is_read;
    logic rd_en;

    // Upper command bits beyond the address/lane widths are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{bus_io.input0[31:ADDR_W], bus_io.input1[31:LaneW]};

    // Position immediately after (addr, lane) in row-major lane order, wrapping at the end.
    function automatic logic [ADDR_W+LaneW-1:0] next_pos(input logic [ADDR_W-1:0] addr,
                                                        input logic [LaneW-1:0]  lane);
        if (lane == LaneW'(LANES - 1)) begin
            return {addr + ADDR_W'(1), LaneW'(0)};
        end
        return {addr, lane + LaneW'(1)};
    endfunction

    assign accept  = bus_io.cmd_valid && (state_q == StIdle);
    assign is_read = (bus_io.funct == FunctSeek) || (bus_io.funct == FunctNext);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = is_read ? StIssue : StResp;
            StIssue: if (!bus_io.c_wr_en) state_d = StWait;
            StWait:  state_d = StResp;
            StResp:  if (bus_io.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus_io.cmd_ready = (state_q == StIdle);
        bus_io.busy      = (state_q != StIdle);
        bus_io.rsp_valid = (state_q == StResp);
        rd_en            = (state_q == StIssue) && !bus_io.c_wr_en;
    end

    assign bus_io.c_rd_en   = rd_en;
    // The address bus keeps the last issued address between strobes.
    assign bus_io.c_rd_addr = rd_en ? cur_addr_q : last_addr_q;
    assign bus_io.rsp_data  = rsp_data_q;

    // Datapath next-state
    always_comb begin
        ptr_addr_d  = ptr_addr_q;
        ptr_lane_d  = ptr_lane_q;
        cur_addr_d  = cur_addr_q;
        cur_lane_d  = cur_lane_q;
        rsp_data_d  = rsp_data_q;
        last_addr_d = rd_en ? cur_addr_q : last_addr_q;

        if (accept) begin
            unique case (bus_io.funct)
                FunctClear: begin
                    ptr_addr_d = '0;
                    ptr_lane_d = '0;
                    rsp_data_d = '0;
                end
                FunctSeek: begin
                    cur_addr_d = bus_io.input0[ADDR_W-1:0];
                    cur_lane_d = bus_io.input1[LaneW-1:0];
                    {ptr_addr_d, ptr_lane_d} =
                        next_pos(bus_io.input0[ADDR_W-1:0], bus_io.input1[LaneW-1:0]);
                end
                FunctNext: begin
                    cur_addr_d = ptr_addr_q;
                    cur_lane_d = ptr_lane_q;
                    {ptr_addr_d, ptr_lane_d} = next_pos(ptr_addr_q, ptr_lane_q);
                end
                default: rsp_data_d = '0;
            endcase
        end

        if (state_q == StWait) begin
            rsp_data_d = bus_io.c_rd_data[{cur_lane_q, 5'd0} +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_addr_q  <= '0;
            ptr_lane_q  <= '0;
            cur_addr_q  <= '0;
            cur_lane_q  <= '0;
            rsp_data_q  <= '0;
            last_addr_q <= '0;
        end else begin
            ptr_addr_q  <= ptr_addr_d;
            ptr_lane_q  <= ptr_lane_d;
            cur_addr_q  <= cur_addr_d;
            cur_lane_q  <= cur_lane_d;
            rsp_data_q  <= rsp_data_d;
            last_addr_q <= last_addr_d;
        end
    end
endmodule
